// File: rtl/flash_word_reader.sv
// flash_word_reader
// CPU-side read master for the 8-bit parallel flash bus. It accepts 32-bit word read
// requests and fetches the four bytes of each word one at a time. Each byte address is
// held for WAIT_CYCLES clocks before FL_DQ is sampled. The bytes are returned as one
// big-endian word: byte offset 0 lands in resp_data[31:24].
//
// Parameters:
//   WAIT_CYCLES  clocks each byte address is held before sampling (1..255)
//   ADDR_W       word-address width; FL_ADDR is ADDR_W+2 bits wide
//
// Ports:
//   clk, Reset_n                   clock, synchronous active-low reset
//   req_valid/req_ready            request handshake, word address on req_word_addr
//   resp_valid/resp_ready          response handshake, word on resp_data
//   busy                           flash access on behalf of a request in progress
//   FL_ADDR, FL_DQ                 flash byte address out, flash data in
//   FL_CE_N, FL_OE_N, FL_WE_N      flash strobes (WE_N is always high)
//   FL_RST_N                       flash reset, registered copy of Reset_n
//
// Optional feature (macro FLASH_PREFETCH_EN):
//   After each completed response for word A, the block speculatively reads word A+1.
//   A later request that matches A+1 is served from that read. Any other request aborts
//   the speculative read.
module flash_word_reader #(
  parameter int unsigned WAIT_CYCLES = 6,
  parameter int unsigned ADDR_W      = 20
) (
  input  logic              clk,
  input  logic              Reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_word_addr,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_data,
  output logic              busy,
  output logic [ADDR_W+1:0] FL_ADDR,
  input  logic [7:0]        FL_DQ,
  output logic              FL_CE_N,
  output logic              FL_OE_N,
  output logic              FL_WE_N,
  output logic              FL_RST_N
);

  typedef enum logic [1:0] {StIdle, StRead, StResp, StPf} state_e;

  localparam logic [7:0] WaitLast = 8'(WAIT_CYCLES);

  state_e            state;
  logic [ADDR_W-1:0] word_addr;
  logic [1:0]        byte_idx;
  logic [7:0]        wait_cnt;
  logic [23:0]       shift;

  logic              sample_now;
  logic              last_byte;
  logic [31:0]       word_done;

`ifdef FLASH_PREFETCH_EN
  logic              pf_valid;
  logic [31:0]       pf_data;
`endif

  // wait_cnt is 1 in the first cycle a byte address is driven, so the byte is sampled
  // at the edge that ends the WAIT_CYCLES-th cycle.
  assign sample_now = (wait_cnt == WaitLast);
  assign last_byte  = sample_now && (byte_idx == 2'd3);
  assign word_done  = {shift, FL_DQ};

  always_ff @(posedge clk) begin
    if (!Reset_n) begin
      state      <= StIdle;
      word_addr  <= '0;
      byte_idx   <= '0;
      wait_cnt   <= '0;
      shift      <= '0;
      req_ready  <= 1'b0;
      resp_valid <= 1'b0;
      resp_data  <= '0;
      busy       <= 1'b0;
      FL_ADDR    <= '0;
      FL_CE_N    <= 1'b1;
      FL_OE_N    <= 1'b1;
      FL_WE_N    <= 1'b1;
      FL_RST_N   <= 1'b0;
`ifdef FLASH_PREFETCH_EN
      pf_valid   <= 1'b0;
      pf_data    <= '0;
`endif
    end else begin
      FL_WE_N  <= 1'b1;
      FL_RST_N <= 1'b1;
      case (state)
        StIdle: begin
          req_ready <= 1'b1;
          if (req_valid && req_ready) begin
`ifdef FLASH_PREFETCH_EN
            pf_valid <= 1'b0;
            // In idle, word_addr still names the word held in pf_data.
            if (pf_valid && (req_word_addr == word_addr)) begin
              resp_data  <= pf_data;
              resp_valid <= 1'b1;
              req_ready  <= 1'b0;
              state      <= StResp;
            end else begin
              word_addr <= req_word_addr;
              FL_ADDR   <= {req_word_addr, 2'b00};
              byte_idx  <= 2'd0;
              wait_cnt  <= 8'd1;
              FL_CE_N   <= 1'b0;
              FL_OE_N   <= 1'b0;
              busy      <= 1'b1;
              req_ready <= 1'b0;
              state     <= StRead;
            end
`else
            word_addr <= req_word_addr;
            FL_ADDR   <= {req_word_addr, 2'b00};
            byte_idx  <= 2'd0;
            wait_cnt  <= 8'd1;
            FL_CE_N   <= 1'b0;
            FL_OE_N   <= 1'b0;
            busy      <= 1'b1;
            req_ready <= 1'b0;
            state     <= StRead;
`endif
          end
        end

        StRead: begin
          if (sample_now) begin
            shift    <= {shift[15:0], FL_DQ};
            wait_cnt <= 8'd1;
            byte_idx <= byte_idx + 2'd1;
            if (!last_byte) begin
              FL_ADDR <= {word_addr, byte_idx + 2'd1};
            end
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
          if (last_byte) begin
            resp_data  <= word_done;
            resp_valid <= 1'b1;
            busy       <= 1'b0;
            FL_CE_N    <= 1'b1;
            FL_OE_N    <= 1'b1;
            state      <= StResp;
          end
        end

        StResp: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            req_ready  <= 1'b1;
`ifdef FLASH_PREFETCH_EN
            // Start the speculative read of the next word; it wraps at the top.
            word_addr <= word_addr + ADDR_W'(1);
            FL_ADDR   <= {word_addr + ADDR_W'(1), 2'b00};
            byte_idx  <= 2'd0;
            wait_cnt  <= 8'd1;
            FL_CE_N   <= 1'b0;
            FL_OE_N   <= 1'b0;
            state     <= StPf;
`else
            state <= StIdle;
`endif
          end
        end

`ifdef FLASH_PREFETCH_EN
        StPf: begin
          if (req_valid && req_ready && (req_word_addr != word_addr)) begin
            // Miss: abandon the speculative read and restart on the requested word.
            word_addr <= req_word_addr;
            FL_ADDR   <= {req_word_addr, 2'b00};
            byte_idx  <= 2'd0;
            wait_cnt  <= 8'd1;
            busy      <= 1'b1;
            req_ready <= 1'b0;
            state     <= StRead;
          end else begin
            if (sample_now) begin
              shift    <= {shift[15:0], FL_DQ};
              wait_cnt <= 8'd1;
              byte_idx <= byte_idx + 2'd1;
              if (!last_byte) begin
                FL_ADDR <= {word_addr, byte_idx + 2'd1};
              end
            end else begin
              wait_cnt <= wait_cnt + 8'd1;
            end
            // A hit turns the speculative read into a real one.
            if (req_valid && req_ready) begin
              busy      <= 1'b1;
              req_ready <= 1'b0;
            end
            if (last_byte) begin
              FL_CE_N <= 1'b1;
              FL_OE_N <= 1'b1;
              if (req_valid && req_ready) begin
                resp_data  <= word_done;
                resp_valid <= 1'b1;
                busy       <= 1'b0;
                state      <= StResp;
              end else begin
                pf_data  <= word_done;
                pf_valid <= 1'b1;
                state    <= StIdle;
              end
            end else if (req_valid && req_ready) begin
              state <= StRead;
            end
          end
        end
`endif

        default: state <= StIdle;
      endcase
    end
  end

endmodule
